instr_imm_packer: RTL

Sequential loader that encodes RV32 immediates into instruction words and writes them into instruction memory. It is the inverse of the immediate sign-extension/decode path: it takes a base word holding opcode, funct and register fields, scatters a 32-bit immediate into the bit positions for the selected format, range-checks it, and writes the result to consecutive instruction-memory addresses. It sits between the test/boot program source and the instruction-memory write port, and runs before the CPU leaves reset.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/imm_pack.sv | 42 ++++
 rtl/instr_imm_packer.sv | 109 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: immediate formats, NOP encoding and loader FSM states.
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  // Immediate format select; the immediate decoder uses the same encoding.
  typedef enum logic [1:0] {
    IMM_I  = 2'b00,
    IMM_S  = 2'b01,
    IMM_SH = 2'b10,
    IMM_B  = 2'b11
  } imm_fmt_e;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    DONE = 2'b10
  } packer_state_e;

endpackage

// File: rtl/imm_pack.sv
// Scatters a 32-bit immediate into the RV32 instruction fields of the selected
// format and reports whether the immediate fits that format.
module imm_pack
  import cpu_pkg::*;
(
  input  imm_fmt_e          fmt,
  input  logic [XLEN-1:0]   base,
  input  logic [XLEN-1:0]   imm,
  output logic [XLEN-1:0]   word,
  output logic              range_ok
);

  // Field replacement keeps the non-immediate bits of base; range check per format.
  always_comb begin
    word     = base;
    range_ok = 1'b0;
    case (fmt)
      IMM_I: begin
        word     = {imm[11:0], base[19:0]};
        range_ok = (imm[31:11] == '0) || (imm[31:11] == '1);
      end
      IMM_S: begin
        word     = {imm[11:5], base[24:12], imm[4:0], base[6:0]};
        range_ok = (imm[31:11] == '0) || (imm[31:11] == '1);
      end
      IMM_SH: begin
        // funct7 (e.g. SRAI bit 30) stays from the base word.
        word     = {base[31:25], imm[4:0], base[19:0]};
        range_ok = (imm[31:5] == '0);
      end
      IMM_B: begin
        word     = {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
        range_ok = ((imm[31:12] == '0) || (imm[31:12] == '1)) && !imm[0];
      end
      default: begin
        word     = base;
        range_ok = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_imm_packer.sv
// Sequential loader: encodes immediates into instruction words and writes them
// to consecutive instruction-memory addresses, tracking range and overflow errors.
module instr_imm_packer
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_fmt,
  input  logic [31:0]       in_base,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_range,
  output logic              err_ovf,
  output logic [ADDR_W-1:0] err_addr,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W-1:0] ADDR_MAX   = '1;
  localparam logic [ADDR_W-1:0] ADDR_FIRST = ADDR_W'(BASE_ADDR);

  packer_state_e     state;
  packer_state_e     state_next;
  logic [ADDR_W-1:0] next_addr;
  logic [31:0]       packed_word;
  logic              range_ok;
  logic              accept;
  logic              restart;

  imm_pack u_imm_pack (
    .fmt      (imm_fmt_e'(in_fmt)),
    .base     (in_base),
    .imm      (in_imm),
    .word     (packed_word),
    .range_ok (range_ok)
  );

  assign in_ready = (state == LOAD);
  assign busy     = (state == LOAD);
  assign done     = (state == DONE);
  assign accept   = in_valid && in_ready;
  assign restart  = start && (state != LOAD);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state: last beat or the top address both end the load.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (start) state_next = LOAD;
      end
      LOAD: begin
        if (accept && (in_last || (next_addr == ADDR_MAX))) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Write port, address/count tracking and sticky error capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      next_addr <= ADDR_FIRST;
      count     <= '0;
      err_range <= 1'b0;
      err_ovf   <= 1'b0;
      err_addr  <= '0;
    end else begin
      mem_we <= 1'b0;
      if (restart) begin
        next_addr <= ADDR_FIRST;
        count     <= '0;
        err_range <= 1'b0;
        err_ovf   <= 1'b0;
        err_addr  <= '0;
      end else if (accept) begin
        mem_we    <= 1'b1;
        mem_addr  <= next_addr;
        mem_wdata <= range_ok ? packed_word : NOP_INSTR;
        count     <= count + (ADDR_W+1)'(1);
        if (!range_ok) begin
          err_range <= 1'b1;
          if (!err_range) err_addr <= next_addr;
        end
        // The address saturates; the last slot ends the load instead of wrapping.
        if (next_addr != ADDR_MAX) next_addr <= next_addr + ADDR_W'(1);
        else if (!in_last)         err_ovf   <= 1'b1;
      end
    end
  end

endmodule
